// File: rtl/counter_seq_5bit.sv
// counter_seq_5bit: loadable up/down modulo counter built around rca_5bit with start/run/done handshake
module rca_5bit (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);
  logic [5:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 5; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[5];
endmodule

module counter_seq_5bit #(
  parameter int MOD  = 32,
  parameter bit CONT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] count,
  output logic       busy,
  output logic       tc,
  output logic       done,
  output logic       wrap
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] MAX = 5'(MOD - 1);
  state_t     state, state_nxt;
  logic [4:0] sum, count_nxt, load_clamped;
  logic       cout_unused, step, wrap_nxt;
  rca_5bit u_add (
    .a    (count),
    .b    (up ? 5'b00001 : 5'b11111),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout_unused)
  );
  assign tc   = up ? (count == MAX) : (count == 5'd0);
  assign busy = state == RUN;
  assign done = state == DONE;
  // a load in RUN steals the cycle, so neither the step nor the terminal transition happens
  always_comb begin
    step         = state == RUN && en && !load;
    wrap_nxt     = step && tc;
    load_clamped = (load_val > MAX) ? MAX : load_val;
    count_nxt    = load ? load_clamped : step ? (tc ? (up ? 5'd0 : MAX) : sum) : count;
    state_nxt    = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? ((wrap_nxt && !CONT) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 5'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_counter_seq_5bit.sv
// tb_counter_seq_5bit: scoreboard bench driving a MOD=10 single-run and a MOD=32 continuous instance in lockstep
module tb_counter_seq_5bit;
  logic       clk = 1'b0;
  logic       rst_n, start, en, up, load;
  logic [4:0] load_val;
  logic [4:0] count10, count32;
  logic       busy10, tc10, done10, wrap10, busy32, tc32, done32, wrap32;
  int         checks = 0, errors = 0;
  typedef struct {int cnt; int st; bit wr;} mdl_t;
  typedef struct {mdl_t a; mdl_t b;} exp_t;
  exp_t sbq[$];
  mdl_t m10, m32;
  always #5 clk = ~clk;
  counter_seq_5bit #(.MOD(10), .CONT(1'b0)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count10), .busy(busy10), .tc(tc10), .done(done10), .wrap(wrap10)
  );
  counter_seq_5bit #(.MOD(32), .CONT(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count32), .busy(busy32), .tc(tc32), .done(done32), .wrap(wrap32)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // st: 0 idle, 1 run, 2 done
  function automatic mdl_t nxt(mdl_t m, int mod, bit cont);
    mdl_t r = m;
    bit   term;
    r.wr = 1'b0;
    if (!rst_n) begin
      r.cnt = 0;
      r.st  = 0;
      return r;
    end
    term = up ? (m.cnt == mod - 1) : (m.cnt == 0);
    case (m.st)
      0: if (start) r.st = 1;
      1: if (en && !load) begin
        r.cnt = (m.cnt + (up ? 1 : mod - 1)) % mod;
        if (term) begin
          r.wr = 1'b1;
          if (!cont) r.st = 2;
        end
      end
      default: r.st = 0;
    endcase
    if (load) r.cnt = (int'(load_val) >= mod) ? mod - 1 : int'(load_val);
    return r;
  endfunction
  task automatic cycle();
    exp_t e;
    e.a = nxt(m10, 10, 1'b0);
    e.b = nxt(m32, 32, 1'b1);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sbq empty");
      return;
    end
    e = sbq.pop_front();
    m10 = e.a;
    m32 = e.b;
    check("cnt10", int'(count10), e.a.cnt);
    check("busy10", int'(busy10), int'(e.a.st == 1));
    check("done10", int'(done10), int'(e.a.st == 2));
    check("wrap10", int'(wrap10), int'(e.a.wr));
    check("tc10", int'(tc10), int'(up ? e.a.cnt == 9 : e.a.cnt == 0));
    check("cnt32", int'(count32), e.b.cnt);
    check("busy32", int'(busy32), int'(e.b.st == 1));
    check("done32", int'(done32), int'(e.b.st == 2));
    check("wrap32", int'(wrap32), int'(e.b.wr));
    check("tc32", int'(tc32), int'(up ? e.b.cnt == 31 : e.b.cnt == 0));
  endtask
  initial begin
    int busy_n, done_n;
    m10 = '{cnt: 0, st: 0, wr: 1'b0};
    m32 = '{cnt: 0, st: 0, wr: 1'b0};
    rst_n = 1'b0; start = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 5'd0;
    repeat (2) begin
      cycle();
      check("rst_cnt", int'(count10), 0);
      check("rst_busy", int'(busy10), 0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) cycle();
    check("idle_hold", int'(count10), 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    busy_n = int'(busy10);
    done_n = 0;
    repeat (12) begin
      cycle();
      busy_n += int'(busy10);
      done_n += int'(done10);
    end
    check("up_busy_len", busy_n, 10);
    check("up_done_pulses", done_n, 1);
    up = 1'b0; load = 1'b1; load_val = 5'd3; start = 1'b1;
    cycle();
    check("ld_start_cnt", int'(count10), 3);
    check("ld_start_busy", int'(busy10), 1);
    load = 1'b0; start = 1'b0;
    repeat (4) cycle();
    check("down_wrap", int'(count10), 9);
    check("down_done", int'(done10), 1);
    cycle();
    load = 1'b1; load_val = 5'd12;
    cycle();
    check("clamp10", int'(count10), 9);
    check("noclamp32", int'(count32), 12);
    up = 1'b1; load_val = 5'd30;
    cycle();
    load = 1'b0;
    check("cont_30", int'(count32), 30);
    cycle();
    check("cont_31", int'(count32), 31);
    cycle();
    check("cont_0", int'(count32), 0);
    check("cont_wrap", int'(wrap32), 1);
    cycle();
    check("cont_1", int'(count32), 1);
    check("cont_wrap_once", int'(wrap32), 0);
    check("cont_busy", int'(busy32), 1);
    start = 1'b1; en = 1'b0;
    cycle();
    start = 1'b0; load = 1'b1; load_val = 5'd5;
    cycle();
    load = 1'b0;
    repeat (3) begin
      cycle();
      check("en_hold", int'(count10), 5);
    end
    load = 1'b1; load_val = 5'd7; en = 1'b1;
    cycle();
    check("ld_prio", int'(count10), 7);
    load_val = 5'd4;
    cycle();
    load = 1'b0; rst_n = 1'b0;
    cycle();
    check("midrst_cnt", int'(count10), 0);
    check("midrst_busy", int'(busy10), 0);
    rst_n = 1'b1;
    cycle();
    check("midrst_nodone", int'(done10), 0);
    repeat (300) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      start    = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 4) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 5'($urandom_range(0, 31));
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
